// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead FIFO with a valid/ready read port.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx         serial input, idle high
//   o_data       byte at FIFO head (0 while empty)
//   o_valid      FIFO non-empty
//   i_ready      consumer accepts o_data; pop when o_valid & i_ready
//   o_count      current FIFO occupancy
//   o_frame_err  sticky: stop bit sampled low
//   o_overflow   sticky: byte dropped because FIFO full
//   i_clr_err    synchronous clear of both sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 278,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_frame_err,
  output logic                     o_overflow,
  input  logic                     i_clr_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   Full    = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Input synchronizer
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push;
  logic            ferr_set;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Mid start bit: a line back high means the edge was a glitch
        if (cnt_q == HalfMax) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          // LSB first: after eight shifts bit 0 lands in shift_q[0]
          shift_d = {rx_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        // Leave at mid-stop so a 1-bit stop followed by a start edge is caught
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s_q) push     = 1'b1;
          else        ferr_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            pop, push_ok, full, ovf_set;
  logic            ferr_q, ovf_q;

  assign full    = (count_q == Full);
  assign pop     = o_valid & i_ready;
  // A full FIFO still accepts the byte if a slot frees up in the same cycle
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + (PtrW + 1)'(1);
    else if (!push_ok && pop) count_d = count_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      if (ferr_set)       ferr_q <= 1'b1;
      else if (i_clr_err) ferr_q <= 1'b0;
      if (ovf_set)        ovf_q  <= 1'b1;
      else if (i_clr_err) ovf_q  <= 1'b0;
    end
  end

  assign o_valid     = (count_q != '0);
  assign o_data      = o_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign o_count     = count_q;
  assign o_frame_err = ferr_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, rx, ready, clr_err;
  logic [7:0] data;
  logic       valid, ferr, ovf;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected FIFO contents and sticky flags
  logic [7:0] exp_q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovf  = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_count(count), .o_frame_err(ferr), .o_overflow(ovf),
    .i_clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Drives one 8N1 frame; the model is updated before the stop bit so a
  // concurrent consumer never sees the DUT byte ahead of the model.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (!stop_ok) m_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovf = 1'b1;
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", ferr); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single_frame();
    send_frame(8'h48, 1'b1);
    idle(2);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", valid); end
    n_checks++; if (data !== exp_q[0]) begin n_fail++; $display("FAIL single_data got %h want %h", data, exp_q[0]); end
    n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL single_count got %0d want %0d", count, exp_q.size()); end
    n_checks++; if ({ferr, ovf} !== {m_ferr, m_ovf}) begin n_fail++; $display("FAIL single_flags got %b%b want %b%b", ferr, ovf, m_ferr, m_ovf); end
    pulse_ready();
    n_checks++; if (valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL single_pop got valid=%b count=%0d want 0/0", valid, count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    int got = 0;
    ready = 1'b1;
    fork
      for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1);
      begin
        int cyc = 0;
        while (got < 5 && cyc < 5 * 10 * CPB + 100) begin
          @(negedge clk);
          cyc++;
          if (valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra got %h want nothing", data);
            end else begin
              logic [7:0] e = exp_q.pop_front();
              if (data !== e) begin n_fail++; $display("FAIL b2b_data got %h want %h", data, e); end
            end
            got++;
          end
        end
      end
    join
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL b2b_timeout got %0d bytes want 5", got); end
    ready = 1'b0;
    idle(2);
    n_checks++; if ({ferr, ovf} !== {m_ferr, m_ovf}) begin n_fail++; $display("FAIL b2b_flags got %b%b want %b%b", ferr, ovf, m_ferr, m_ovf); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_count got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(2);
    n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", count, exp_q.size()); end
    n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL ovf_flag got %b want %b", ovf, m_ovf); end
    while (exp_q.size() > 0) begin
      n_checks++; if (data !== exp_q[0]) begin n_fail++; $display("FAIL ovf_drain got %h want %h", data, exp_q[0]); end
      pulse_ready();
    end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", valid); end
    pulse_clr();
    n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL ovf_clear got %b want %b", ovf, m_ovf); end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA5, 1'b0);
    idle(2 * CPB);
    n_checks++; if (ferr !== m_ferr) begin n_fail++; $display("FAIL ferr_flag got %b want %b", ferr, m_ferr); end
    n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL ferr_count got %0d want %0d", count, exp_q.size()); end
    send_frame(8'h3C, 1'b1);
    idle(2);
    n_checks++; if (valid !== 1'b1 || data !== exp_q[0]) begin n_fail++; $display("FAIL ferr_next got %b/%h want 1/%h", valid, data, exp_q[0]); end
    pulse_ready();
    pulse_clr();
    n_checks++; if (ferr !== m_ferr) begin n_fail++; $display("FAIL ferr_clear got %b want %b", ferr, m_ferr); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * CPB);
    n_checks++; if (count !== 3'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL glitch_count got %0d want 0", count); end
    n_checks++; if ({ferr, ovf} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags got %b%b want 00", ferr, ovf); end
    send_frame(8'h7E, 1'b1);
    idle(2);
    n_checks++; if (data !== exp_q[0] || count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL glitch_next got %h/%0d want %h/%0d", data, count, exp_q[0], exp_q.size()); end
    pulse_ready();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h99;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rmf_queued got %0d want %0d", count, exp_q.size()); end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin rx = b[i]; repeat (CPB) @(negedge clk); end
    rx = b[3];
    repeat (CPB / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete(); m_ferr = 1'b0; m_ovf = 1'b0;
    n_checks++; if (valid !== 1'b0 || count !== 3'd0 || data !== 8'h00) begin n_fail++; $display("FAIL rmf_outputs got %b/%0d/%h want 0/0/00", valid, count, data); end
    n_checks++; if ({ferr, ovf} !== 2'b00) begin n_fail++; $display("FAIL rmf_flags got %b%b want 00", ferr, ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    send_frame(8'h55, 1'b1);
    idle(2);
    n_checks++; if (count !== 3'd1 || data !== 8'h55) begin n_fail++; $display("FAIL rmf_after got %0d/%h want 1/55", count, data); end
    pulse_ready();
  endtask

  task automatic test_random();
    logic [7:0] bytes [8];
    logic       ok [8];
    int n_good = 0, got = 0;
    for (int i = 0; i < 8; i++) begin
      bytes[i] = 8'($urandom);
      ok[i]    = ($urandom_range(0, 4) != 0);
      if (ok[i]) n_good++;
    end
    ready = 1'b1;
    fork
      for (int i = 0; i < 8; i++) begin
        send_frame(bytes[i], ok[i]);
        if (!ok[i]) idle(2 * CPB);
        idle($urandom_range(0, CPB));
      end
      begin
        int cyc = 0;
        while (got < n_good && cyc < 8 * 14 * CPB + 200) begin
          @(negedge clk);
          cyc++;
          if (valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_extra got %h want nothing", data);
            end else begin
              logic [7:0] e = exp_q.pop_front();
              if (data !== e) begin n_fail++; $display("FAIL rand_data got %h want %h", data, e); end
            end
            got++;
          end
        end
      end
    join
    ready = 1'b0;
    idle(2);
    n_checks++; if (got != n_good) begin n_fail++; $display("FAIL rand_timeout got %0d bytes want %0d", got, n_good); end
    n_checks++; if ({ferr, ovf} !== {m_ferr, m_ovf}) begin n_fail++; $display("FAIL rand_flags got %b%b want %b%b", ferr, ovf, m_ferr, m_ovf); end
    pulse_clr();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
